breadboard: RTL and testbench

// - Four-way intersection traffic-light controller: directions S, E, N, W, two lanes each, one green/red bit per lane.
// - Selects day, night, pedestrian or emergency mode and times each green phase with a down-counter.
// - Loads depend on the queued car counts per lane.
// - Top of the traffic design: fed by the hour-of-day source, lane sensors and request buttons; drives the lamp outputs.

---
 rtl/traffic_pkg.sv | 99 +++++++++
 rtl/breadboard_if.sv | 26 ++
 rtl/countdown_timer.sv | 46 ++++
 rtl/breadboard.sv | 125 ++++++++++++
 tb/tb_breadboard.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types, constants and helpers for the four-way traffic controller.
//   - mode_t  : controller mode codes (day, night, pedestrian, emergency)
//   - phase_t : green direction, ring order S -> E -> N -> W -> S
//   - load constants for each phase type and the lamp mask per direction
//   - helpers: hour decode, per-direction queue maximum, emergency lane decode,
//     and the night-mode search for the next occupied direction
// -----------------------------------------------------------------------------
package traffic_pkg;

    localparam int CNT_W = 7;

    localparam logic [CNT_W-1:0] DAY_BASE = 7'd16;
    localparam logic [CNT_W-1:0] NIGHT_LD = 7'd8;
    localparam logic [CNT_W-1:0] PED_LD   = 7'd20;
    localparam logic [CNT_W-1:0] EMG_LD   = 7'd30;

    localparam logic [7:0] MASK_S = 8'h03;
    localparam logic [7:0] MASK_E = 8'h0C;
    localparam logic [7:0] MASK_N = 8'h30;
    localparam logic [7:0] MASK_W = 8'hC0;

    typedef enum logic [1:0] {
        MODE_DAY   = 2'b00,
        MODE_NIGHT = 2'b01,
        MODE_PED   = 2'b10,
        MODE_EMG   = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        PH_S = 2'd0,
        PH_E = 2'd1,
        PH_N = 2'd2,
        PH_W = 2'd3
    } phase_t;

    // Day covers 06:00 through 17:59; anything else, including out-of-range
    // hour values, is night.
    function automatic logic is_day(input logic [4:0] hours);
        return (hours >= 5'd6) && (hours <= 5'd17);
    endfunction

    function automatic logic [7:0] lamp_mask(input phase_t p);
        logic [7:0] m;
        case (p)
            PH_S:    m = MASK_S;
            PH_E:    m = MASK_E;
            PH_N:    m = MASK_N;
            PH_W:    m = MASK_W;
            default: m = MASK_S;
        endcase
        return m;
    endfunction

    // Larger of the two lane queues of a direction.
    // Lane word layout is {w1,w2,s1,s2,e1,e2,n1,n2}, w1 in the top byte.
    function automatic logic [7:0] lane_max(input logic [63:0] lanes, input phase_t p);
        logic [7:0] a;
        logic [7:0] b;
        case (p)
            PH_S:    begin a = lanes[47:40]; b = lanes[39:32]; end
            PH_E:    begin a = lanes[31:24]; b = lanes[23:16]; end
            PH_N:    begin a = lanes[15:8];  b = lanes[7:0];   end
            PH_W:    begin a = lanes[63:56]; b = lanes[55:48]; end
            default: begin a = 8'd0;         b = 8'd0;         end
        endcase
        return (a > b) ? a : b;
    endfunction

    // Direction owning the lowest set emergency lane bit (two bits per direction).
    function automatic phase_t emg_dir(input logic [7:0] lane);
        phase_t d;
        d = PH_S;
        for (int i = 7; i >= 0; i--) begin
            if (lane[i]) begin
                d = phase_t'(i[2:1]);
            end
        end
        return d;
    endfunction

    // First direction at or after 'start' (ring order) with a nonzero queue.
    // Result is {found, direction}; found=0 means every lane is empty.
    function automatic logic [2:0] night_pick(input logic [63:0] lanes, input phase_t start);
        logic [2:0] res;
        phase_t     cand;
        res = 3'b000;
        // Walk offsets from far to near so the nearest occupied direction wins.
        for (int k = 3; k >= 0; k--) begin
            cand = phase_t'(start + k[1:0]);
            if (lane_max(lanes, cand) != 8'd0) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/breadboard_if.sv
// -----------------------------------------------------------------------------
// breadboard_if
// Bundles the controller's environment signals.
//   master (environment): drives hoursIn, pedSignal, emgSignal, emgLane, lanes;
//                         observes trafficLightOutput, walkingLightOutput
//   slave  (controller) : the reverse
// -----------------------------------------------------------------------------
interface breadboard_if;
    logic [4:0]  hoursIn;
    logic        pedSignal;
    logic        emgSignal;
    logic [7:0]  emgLane;
    logic [63:0] lanes;
    logic [7:0]  trafficLightOutput;
    logic [7:0]  walkingLightOutput;

    modport master (
        output hoursIn, pedSignal, emgSignal, emgLane, lanes,
        input  trafficLightOutput, walkingLightOutput
    );

    modport slave (
        input  hoursIn, pedSignal, emgSignal, emgLane, lanes,
        output trafficLightOutput, walkingLightOutput
    );
endinterface

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
// Phase timer: loads a new duration on 'load', otherwise counts down and
// holds at zero.
//   clk, rst_n : clock, asynchronous active-low reset (count clears to 0)
//   load       : take loadIn this cycle
//   loadIn     : duration to load
//   isZero     : count has run out
// -----------------------------------------------------------------------------
module countdown_timer
    import traffic_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] loadIn,
    output logic             isZero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = loadIn;
        end else if (count_q != {CNT_W{1'b0}}) begin
            count_d = count_q - 7'd1;
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {CNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign isZero = (count_q == {CNT_W{1'b0}});

endmodule

// File: rtl/breadboard.sv
// -----------------------------------------------------------------------------
// breadboard
// Four-way intersection controller: picks day / night / pedestrian /
// emergency operation, steps the green direction round the S-E-N-W ring and
// times each phase with countdown_timer.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : breadboard_if.slave (hour, sensors, requests in; lamps out)
// -----------------------------------------------------------------------------
module breadboard
    import traffic_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    breadboard_if.slave bus
);

    mode_t            mode_q,    mode_d;
    phase_t           phase_q,   phase_d;
    logic             valid_q,   valid_d;     // a direction has been green since reset
    logic             ped_q,     ped_d;       // latched pedestrian request
    logic [7:0]       traffic_q, traffic_d;
    logic [7:0]       walk_q,    walk_d;

    logic             load_s;
    logic [CNT_W-1:0] load_in_s;
    logic             is_zero_s;
    logic             emg_req_s;
    logic             day_night_s;
    phase_t           ring_start_s;
    logic [7:0]       day_max_s;
    logic [2:0]       night_pick_s;

    countdown_timer u_timer (
        .clk    (clk),
        .rst_n  (rst),
        .load   (load_s),
        .loadIn (load_in_s),
        .isZero (is_zero_s)
    );

    // Mode/phase decision and load selection.
    always_comb begin
        emg_req_s   = bus.emgSignal && (bus.emgLane != 8'h00);
        day_night_s = is_day(bus.hoursIn);
        // Before the first green the ring starts at the reset phase itself.
        ring_start_s = valid_q ? phase_t'(phase_q + 2'd1) : phase_q;
        day_max_s    = lane_max(bus.lanes, ring_start_s);
        night_pick_s = night_pick(bus.lanes, ring_start_s);

        mode_d    = mode_q;
        phase_d   = phase_q;
        valid_d   = valid_q;
        ped_d     = ped_q | bus.pedSignal;
        traffic_d = traffic_q;
        walk_d    = walk_q;
        load_s    = 1'b0;
        load_in_s = {CNT_W{1'b0}};

        if (emg_req_s) begin
            // Preempt immediately and keep reloading while the request holds.
            load_s    = 1'b1;
            load_in_s = EMG_LD;
            mode_d    = MODE_EMG;
            phase_d   = emg_dir(bus.emgLane);
            valid_d   = 1'b1;
            traffic_d = lamp_mask(phase_d);
            walk_d    = 8'h00;
        end else if (is_zero_s) begin
            load_s = 1'b1;
            if (ped_d) begin
                // phase_q keeps the last green so the ring resumes after it.
                mode_d    = MODE_PED;
                traffic_d = 8'h00;
                walk_d    = 8'hFF;
                load_in_s = PED_LD;
                ped_d     = 1'b0;
            end else if (day_night_s) begin
                mode_d    = MODE_DAY;
                phase_d   = ring_start_s;
                valid_d   = 1'b1;
                traffic_d = lamp_mask(phase_d);
                walk_d    = 8'h00;
                load_in_s = DAY_BASE + CNT_W'(day_max_s >> 2);
            end else begin
                mode_d    = MODE_NIGHT;
                // Empty intersection: stay on the current direction.
                if (night_pick_s[2]) begin
                    phase_d = phase_t'(night_pick_s[1:0]);
                end else begin
                    phase_d = phase_q;
                end
                valid_d   = 1'b1;
                traffic_d = lamp_mask(phase_d);
                walk_d    = 8'h00;
                load_in_s = NIGHT_LD;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Controller state and registered lamp outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q    <= MODE_DAY;
            phase_q   <= PH_S;
            valid_q   <= 1'b0;
            ped_q     <= 1'b0;
            traffic_q <= 8'h00;
            walk_q    <= 8'h00;
        end else begin
            mode_q    <= mode_d;
            phase_q   <= phase_d;
            valid_q   <= valid_d;
            ped_q     <= ped_d;
            traffic_q <= traffic_d;
            walk_q    <= walk_d;
        end
    end

    assign bus.trafficLightOutput = traffic_q;
    assign bus.walkingLightOutput = walk_q;

endmodule

// File: tb/tb_breadboard.sv
// -----------------------------------------------------------------------------
// tb_breadboard
// Directed self-checking bench for the traffic controller. Inputs change and
// outputs are sampled on the falling clock edge; the controller acts on the
// rising edge. A phase loaded with value L shows its lamps while the count
// runs L..0, and the next phase appears on the clock after the count is zero.
// -----------------------------------------------------------------------------
module tb_breadboard;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    logic [4:0] hour_tab_r [7] = '{5'd5, 5'd6, 5'd17, 5'd18, 5'd24, 5'd0, 5'd23};
    logic       day_tab_r  [7] = '{1'b0, 1'b1, 1'b1,  1'b0,  1'b0,  1'b0, 1'b0};

    breadboard_if bus_if ();

    breadboard dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Lamps, controller mode and remaining count at the current sample point.
    task automatic observe(input string tag, input logic [7:0] traffic, input logic [7:0] walk,
                           input logic [1:0] mode, input logic [6:0] count);
        check({tag, ".traffic"}, 64'(bus_if.trafficLightOutput), 64'(traffic));
        check({tag, ".walk"},    64'(bus_if.walkingLightOutput), 64'(walk));
        check({tag, ".mode"},    64'(dut.mode_q),                64'(mode));
        check({tag, ".count"},   64'(dut.u_timer.count_q),       64'(count));
    endtask

    // Directed scenarios.
    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus_if.hoursIn   = 5'd12;
        bus_if.pedSignal = 1'b0;
        bus_if.emgSignal = 1'b0;
        bus_if.emgLane   = 8'h00;
        bus_if.lanes     = 64'd0;
        bus_if.lanes[47:40] = 8'd127;   // s1
        bus_if.lanes[15:8]  = 8'd7;     // n1
        #1 rst = 1'b0;
        tick(2);
        observe("reset", 8'h00, 8'h00, 2'b00, 7'd0);

        // Day ring: S 16+127/4=47, E 16, N 16+7/4=17, W 16, back to S.
        rst = 1'b1;
        tick(1);  observe("day_s_load", 8'h03, 8'h00, 2'b00, 7'd47);
        tick(47); observe("day_s_end",  8'h03, 8'h00, 2'b00, 7'd0);
        tick(1);  observe("day_e_load", 8'h0C, 8'h00, 2'b00, 7'd16);
        tick(16); observe("day_e_end",  8'h0C, 8'h00, 2'b00, 7'd0);
        tick(1);  observe("day_n_load", 8'h30, 8'h00, 2'b00, 7'd17);
        tick(17); observe("day_n_end",  8'h30, 8'h00, 2'b00, 7'd0);
        tick(1);  observe("day_w_load", 8'hC0, 8'h00, 2'b00, 7'd16);
        tick(16);
        tick(1);  observe("day_s_again", 8'h03, 8'h00, 2'b00, 7'd47);

        // Night, only n1 occupied: N repeats in 8-count phases.
        rst = 1'b0;
        tick(1);
        bus_if.hoursIn = 5'd2;
        bus_if.lanes   = 64'd0;
        bus_if.lanes[15:8] = 8'd7;
        rst = 1'b1;
        tick(1); observe("night_n_load",  8'h30, 8'h00, 2'b01, 7'd8);
        tick(8); observe("night_n_end",   8'h30, 8'h00, 2'b01, 7'd0);
        tick(1); observe("night_n_again", 8'h30, 8'h00, 2'b01, 7'd8);

        // Emergency during a day S phase (all queues empty).
        rst = 1'b0;
        tick(1);
        bus_if.hoursIn = 5'd12;
        bus_if.lanes   = 64'd0;
        rst = 1'b1;
        tick(1); observe("emg_pre_s", 8'h03, 8'h00, 2'b00, 7'd16);
        bus_if.emgSignal = 1'b1;
        bus_if.emgLane   = 8'h00;
        tick(1); observe("emg_lane0_ignored", 8'h03, 8'h00, 2'b00, 7'd15);
        tick(2);
        bus_if.emgLane = 8'b0000_1000;
        tick(1); observe("emg_preempt_e", 8'h0C, 8'h00, 2'b11, 7'd30);
        bus_if.emgLane = 8'b1010_0000;
        tick(1); observe("emg_lowest_bit", 8'h30, 8'h00, 2'b11, 7'd30);
        bus_if.emgLane = 8'b0000_1000;
        tick(1); observe("emg_hold", 8'h0C, 8'h00, 2'b11, 7'd30);
        bus_if.emgSignal = 1'b0;
        bus_if.emgLane   = 8'h00;
        tick(30); observe("emg_runout",   8'h0C, 8'h00, 2'b11, 7'd0);
        tick(1);  observe("emg_resume_n", 8'h30, 8'h00, 2'b00, 7'd16);

        // Pedestrian pulse mid-phase, served when N runs out, then W.
        tick(4);
        bus_if.pedSignal = 1'b1;
        tick(1);
        bus_if.pedSignal = 1'b0;
        observe("ped_pending", 8'h30, 8'h00, 2'b00, 7'd11);
        tick(11); observe("ped_wait_end", 8'h30, 8'h00, 2'b00, 7'd0);
        tick(1);  observe("ped_phase",    8'h00, 8'hFF, 2'b10, 7'd20);
        tick(20); observe("ped_end",      8'h00, 8'hFF, 2'b10, 7'd0);
        tick(1);  observe("ped_resume_w", 8'hC0, 8'h00, 2'b00, 7'd16);

        // Asynchronous reset mid-phase: lamps drop before the next clock edge.
        tick(5);
        #2 rst = 1'b0;
        #1;
        observe("async_reset", 8'h00, 8'h00, 2'b00, 7'd0);
        @(negedge clk);
        rst = 1'b1;
        tick(1); observe("restart_s", 8'h03, 8'h00, 2'b00, 7'd16);

        // Day/night decode at the boundaries and out of range.
        for (int i = 0; i < 7; i++) begin
            bus_if.hoursIn = hour_tab_r[i];
            #1;
            check($sformatf("day_night_h%0d", hour_tab_r[i]), 64'(dut.day_night_s), 64'(day_tab_r[i]));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
